bus_responder: RTL and testbench
================================

BUS_RESPONDER -- requirements
Module: bus_responder

Interface
REQ-001 Parameter TIMEOUT, default 255, the number of WAIT cycles without slave ack/err before the block returns a bus error.
REQ-002 Parameter NSLAVE, default 8, the number of slave ports; index 0 means no slave.
REQ-003 clk_i  in  1  single clock; all logic samples on the rising edge.
REQ-004 rst_i  in  1  synchronous, active-high reset.
REQ-005 cyc_i, stb_i, we_i  in  1 each  master Wishbone cycle, strobe and write enable.
REQ-006 adr_i  in  32, dat_i  in  32, sel_i  in  4  master address, write data and byte selects.
REQ-007 chipselect  in  4, fault  in  1  slave index and access fault from the address decoder, valid while cyc_i is high.
REQ-008 dat_o  out  32, ack_o  out  1, err_o  out  1  master read data, acknowledge and error.
REQ-009 s_cyc_o  out  NSLAVE  one-hot slave cycle; bit n selects slave n.
REQ-010 s_stb_o, s_we_o  out  1 each; s_adr_o  out  32; s_dat_o  out  32; s_sel_o  out  4  shared slave request.
REQ-011 s_dat_i  in  32*NSLAVE; s_ack_i  in  NSLAVE; s_err_i  in  NSLAVE  per-slave response; slave n uses bits [32n+31:32n].
REQ-012 buserr_adr_o  out  32  address of the most recent errored access.
REQ-013 timeout_o  out  1  one-cycle pulse when a watchdog timeout fires.

Function
REQ-014 The FSM SHALL have four states: IDLE, WAIT, RESP (ack), ERR.
REQ-015 IDLE: when cyc_i&stb_i is sampled with fault=1 or chipselect=0, the FSM SHALL go to ERR; otherwise it SHALL register cs, adr, dat, sel and we, then go to WAIT.
REQ-016 In WAIT, s_cyc_o[cs] and s_stb_o SHALL be 1 and all other s_cyc_o bits 0; in every other state, s_cyc_o=0 and s_stb_o=0.
REQ-017 s_adr_o, s_dat_o, s_sel_o and s_we_o SHALL be the registered copies and SHALL stay stable throughout WAIT.
REQ-018 In WAIT, s_ack_i[cs] SHALL register s_dat_i[cs] into dat_o and move the FSM to RESP.
REQ-019 In WAIT, s_err_i[cs] SHALL move the FSM to ERR; when s_ack_i[cs] and s_err_i[cs] are high together, err wins.
REQ-020 ack/err from any slave other than cs SHALL be ignored.
REQ-021 The watchdog SHALL count WAIT cycles from 0; at count TIMEOUT-1 with no ack/err, the FSM SHALL go to ERR and pulse timeout_o in the ERR cycle.
REQ-022 An ack on the same edge as the timeout SHALL win: no error and no timeout_o.
REQ-023 RESP SHALL drive ack_o=1 for exactly one cycle; ERR SHALL drive err_o=1 for exactly one cycle; both states then return to IDLE.
REQ-024 Latency: a slave ack sampled at edge m SHALL give ack_o high in cycle m+1; a decode fault sampled at edge k SHALL give err_o high in cycle k+1.
REQ-025 On entry to ERR, buserr_adr_o SHALL load the registered or decoded address; it SHALL hold between errors.
REQ-026 cyc_i dropping during WAIT SHALL abort: the FSM returns to IDLE next edge with no ack_o or err_o, and the watchdog clears.
REQ-027 ack_o and err_o SHALL never both be high in the same cycle.
REQ-028 dat_o SHALL hold its last value outside RESP.

Reset
REQ-029 rst_i SHALL force IDLE, clear the watchdog, and zero every output register (dat_o, ack_o, err_o, s_* outputs, buserr_adr_o, timeout_o).
REQ-030 rst_i asserted mid-WAIT SHALL drop s_cyc_o/s_stb_o on the next edge with no ack_o/err_o issued.

Structure
REQ-031 A shared package bexkat_bus_pkg SHALL hold the state enum, the NSLAVE default, the 4-bit chipselect typedef and the TIMEOUT default.
REQ-032 The watchdog SHALL be a sub-module bus_watchdog (clear, enable, expire output, parameter TIMEOUT).

Verification
REQ-033 Read: adr 0x00000010, cs=7, slave 7 acks after 3 wait cycles with 0xDEADBEEF -> s_cyc_o=0x80 during WAIT; ack_o one cycle later with dat_o=0xDEADBEEF.
REQ-034 Decode fault: adr 0x50000000, fault=1, cs=0 -> err_o in the next cycle; buserr_adr_o=0x50000000; no s_cyc_o activity.
REQ-035 Timeout: cs=4 with no slave response, TIMEOUT=16 -> err_o and timeout_o after 16 WAIT cycles; buserr_adr_o = request address.
REQ-036 Contention: in WAIT with cs=2, s_ack_i[5]=1 -> ignored; then s_ack_i[2] and s_err_i[2] high together -> err_o, no ack_o.
REQ-037 Abort/reset: cyc_i dropped in WAIT cycle 2 -> IDLE, no response; repeat with rst_i instead -> all outputs zero on the next cycle.
REQ-038 Back-to-back: two writes to cs=5 and cs=6 with immediate acks -> two single-cycle ack_o pulses; s_dat_o and s_sel_o match each request.

Source files
------------

// File: rtl/bexkat_bus_pkg.sv
// Shared types and defaults for the bus responder and its watchdog.
package bexkat_bus_pkg;

  localparam int NSLAVE_DEF  = 8;
  localparam int TIMEOUT_DEF = 255;

  typedef logic [3:0] cs_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP,
    ST_ERR
  } bus_state_t;

endpackage

// File: rtl/bus_responder_if.sv
// Master-side Wishbone request/response plus the fanned-out slave request/response bundle.
interface bus_responder_if #(
  parameter int NSLAVE = bexkat_bus_pkg::NSLAVE_DEF
);
  import bexkat_bus_pkg::*;

  logic                 cyc_i;
  logic                 stb_i;
  logic                 we_i;
  logic [31:0]          adr_i;
  logic [31:0]          dat_i;
  logic [3:0]           sel_i;
  cs_t                  chipselect;
  logic                 fault;
  logic [31:0]          dat_o;
  logic                 ack_o;
  logic                 err_o;
  logic [NSLAVE-1:0]    s_cyc_o;
  logic                 s_stb_o;
  logic                 s_we_o;
  logic [31:0]          s_adr_o;
  logic [31:0]          s_dat_o;
  logic [3:0]           s_sel_o;
  logic [32*NSLAVE-1:0] s_dat_i;
  logic [NSLAVE-1:0]    s_ack_i;
  logic [NSLAVE-1:0]    s_err_i;
  logic [31:0]          buserr_adr_o;
  logic                 timeout_o;

  modport slave (
    input  cyc_i, stb_i, we_i, adr_i, dat_i, sel_i, chipselect, fault,
    input  s_dat_i, s_ack_i, s_err_i,
    output dat_o, ack_o, err_o, s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o, s_sel_o,
    output buserr_adr_o, timeout_o
  );

  modport master (
    output cyc_i, stb_i, we_i, adr_i, dat_i, sel_i, chipselect, fault,
    output s_dat_i, s_ack_i, s_err_i,
    input  dat_o, ack_o, err_o, s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o, s_sel_o,
    input  buserr_adr_o, timeout_o
  );

endinterface

// File: rtl/bus_watchdog.sv
// Down-counting WAIT watchdog: reloads on clear, expires on the TIMEOUT-th enabled cycle.
module bus_watchdog #(
  parameter int TIMEOUT = 255
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int             CW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0]  LOAD = CW'(TIMEOUT - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk_i) begin
    if (rst_i || clear) begin
      count <= LOAD;
    end else if (enable && (count != '0)) begin
      count <= count - CW'(1);
    end
  end

  assign expire = enable && (count == '0);

endmodule

// File: rtl/bus_responder.sv
// Routes one Wishbone master onto NSLAVE slaves picked by an external decoder;
// silent slaves are turned into bus errors by the watchdog.
module bus_responder
  import bexkat_bus_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int NSLAVE  = NSLAVE_DEF
) (
  input  logic           clk_i,
  input  logic           rst_i,
  bus_responder_if.slave bus
);
  // state | meaning
  // IDLE  | waiting for cyc_i & stb_i; decode faults go straight to ERR
  // WAIT  | slave cs selected, waiting for its ack/err or the watchdog
  // RESP  | one-cycle ack_o carrying the captured read data
  // ERR   | one-cycle err_o; timeout_o set when the watchdog caused it

  localparam logic [NSLAVE-1:0] CS_ONE = NSLAVE'(1);

  bus_state_t  state, state_nxt;
  cs_t         cs_q;
  logic [31:0] adr_q, wdat_q, rdat_q, buserr_q;
  logic [3:0]  sel_q;
  logic        we_q, tmo_q;
  logic        req, dec_bad, sel_ack, sel_err, wd_expire, to_tmo;
  logic [31:0] sel_dat;

  assign req     = bus.cyc_i & bus.stb_i;
  assign dec_bad = bus.fault | (bus.chipselect == '0);

  // Only the captured slave's response is visible; everything else is ignored.
  always_comb begin
    sel_ack = 1'b0;
    sel_err = 1'b0;
    sel_dat = '0;
    for (int n = 0; n < NSLAVE; n++) begin
      if (cs_q == cs_t'(n)) begin
        sel_ack = bus.s_ack_i[n];
        sel_err = bus.s_err_i[n];
        sel_dat = bus.s_dat_i[32*n +: 32];
      end
    end
  end

  bus_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .clear  (state != ST_WAIT),
    .enable (state == ST_WAIT),
    .expire (wd_expire)
  );

  always_comb begin
    state_nxt = state;
    to_tmo    = 1'b0;
    case (state)
      ST_IDLE: if (req) state_nxt = dec_bad ? ST_ERR : ST_WAIT;
      ST_WAIT: begin
        // Abort beats everything; err beats ack; ack beats a same-edge expiry.
        if (!bus.cyc_i)     state_nxt = ST_IDLE;
        else if (sel_err)   state_nxt = ST_ERR;
        else if (sel_ack)   state_nxt = ST_RESP;
        else if (wd_expire) begin
          state_nxt = ST_ERR;
          to_tmo    = 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= ST_IDLE;
      cs_q     <= '0;
      adr_q    <= '0;
      wdat_q   <= '0;
      sel_q    <= '0;
      we_q     <= 1'b0;
      rdat_q   <= '0;
      buserr_q <= '0;
      tmo_q    <= 1'b0;
    end else begin
      state <= state_nxt;
      tmo_q <= to_tmo;
      if ((state == ST_IDLE) && req && !dec_bad) begin
        cs_q   <= bus.chipselect;
        adr_q  <= bus.adr_i;
        wdat_q <= bus.dat_i;
        sel_q  <= bus.sel_i;
        we_q   <= bus.we_i;
      end
      if ((state == ST_WAIT) && (state_nxt == ST_RESP)) rdat_q <= sel_dat;
      if (state_nxt == ST_ERR) buserr_q <= (state == ST_IDLE) ? bus.adr_i : adr_q;
    end
  end

  assign bus.ack_o        = (state == ST_RESP);
  assign bus.err_o        = (state == ST_ERR);
  assign bus.timeout_o    = tmo_q;
  assign bus.dat_o        = rdat_q;
  assign bus.buserr_adr_o = buserr_q;
  assign bus.s_stb_o      = (state == ST_WAIT);
  assign bus.s_cyc_o      = (state == ST_WAIT) ? (CS_ONE << cs_q) : '0;
  assign bus.s_adr_o      = adr_q;
  assign bus.s_dat_o      = wdat_q;
  assign bus.s_sel_o      = sel_q;
  assign bus.s_we_o       = we_q;

endmodule

// File: tb/tb_bus_responder.sv
// Self-checking bench for bus_responder: directed vector table, hand sequences and
// randomized transactions scored by a transaction-level outcome model.
module tb_bus_responder;

  localparam int TIMEOUT = 16;
  localparam int NSLAVE  = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;
  string ctx = "";

  logic [31:0] last_dat    = '0;
  logic [31:0] last_buserr = '0;

  always #5 clk = ~clk;

  bus_responder_if #(.NSLAVE(NSLAVE)) bus ();

  bus_responder #(.TIMEOUT(TIMEOUT), .NSLAVE(NSLAVE)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  // resp: 0 none, 1 ack, 2 err, 3 ack+err together; d = WAIT index the response appears in
  typedef struct {
    logic [3:0]  cs;
    logic        fault;
    logic [31:0] adr;
    logic [31:0] wdat;
    logic [3:0]  sel;
    logic        we;
    int          d;
    int          resp;
    logic [31:0] rdata;
    logic        exp_ack;
    logic        exp_tmo;
    int          exp_waits;
    logic [31:0] exp_dat;
    logic [31:0] exp_buserr;
  } vec_t;

  vec_t tbl[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s/%s: got %h expected %h", ctx, name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [3:0] cs, input logic fault, input logic [31:0] adr,
                              input logic [31:0] wdat, input logic [3:0] sel, input logic we,
                              input int d, input int resp, input logic [31:0] rdata,
                              input logic exp_ack, input logic exp_tmo, input int exp_waits,
                              input logic [31:0] exp_dat, input logic [31:0] exp_buserr);
    vec_t v;
    v.cs = cs; v.fault = fault; v.adr = adr; v.wdat = wdat; v.sel = sel; v.we = we;
    v.d = d; v.resp = resp; v.rdata = rdata;
    v.exp_ack = exp_ack; v.exp_tmo = exp_tmo; v.exp_waits = exp_waits;
    v.exp_dat = exp_dat; v.exp_buserr = exp_buserr;
    return v;
  endfunction

  // Outcome of one transaction derived from the rules, independent of any state encoding.
  task automatic model(inout vec_t v);
    v.exp_ack = 1'b0;
    v.exp_tmo = 1'b0;
    if (v.fault || v.cs == 4'd0) begin
      v.exp_waits = 0;
      last_buserr = v.adr;
    end else if (v.resp != 0 && v.d < TIMEOUT) begin
      v.exp_waits = v.d + 1;
      if (v.resp == 1) begin
        v.exp_ack = 1'b1;
        last_dat  = v.rdata;
      end else begin
        last_buserr = v.adr;
      end
    end else begin
      v.exp_tmo   = 1'b1;
      v.exp_waits = TIMEOUT;
      last_buserr = v.adr;
    end
    v.exp_dat    = last_dat;
    v.exp_buserr = last_buserr;
  endtask

  task automatic drive_idle();
    bus.cyc_i = 1'b0; bus.stb_i = 1'b0; bus.we_i = 1'b0;
    bus.adr_i = '0; bus.dat_i = '0; bus.sel_i = '0;
    bus.chipselect = '0; bus.fault = 1'b0;
    bus.s_dat_i = '0; bus.s_ack_i = '0; bus.s_err_i = '0;
  endtask

  task automatic run_txn(input vec_t v);
    int waits = 0;
    int cyc_bad = 0;
    int req_bad = 0;
    int both = 0;
    bit done = 1'b0;
    bit got_ack = 1'b0;
    bit got_err = 1'b0;
    bit got_tmo = 1'b0;
    int idx = int'(v.cs);
    logic [NSLAVE-1:0] exp_oh = '0;
    exp_oh[v.cs[2:0]] = 1'b1;
    bus.cyc_i = 1'b1; bus.stb_i = 1'b1; bus.we_i = v.we;
    bus.adr_i = v.adr; bus.dat_i = v.wdat; bus.sel_i = v.sel;
    bus.chipselect = v.cs; bus.fault = v.fault;
    bus.s_ack_i = '0; bus.s_err_i = '0;
    for (int c = 0; c < TIMEOUT + 6 && !done; c++) begin
      @(negedge clk);
      if (bus.ack_o && bus.err_o) both++;
      if (bus.ack_o) begin got_ack = 1'b1; done = 1'b1; end
      if (bus.err_o) begin got_err = 1'b1; got_tmo = bus.timeout_o; done = 1'b1; end
      bus.s_ack_i = NSLAVE'($urandom) & ~exp_oh;
      bus.s_err_i = NSLAVE'($urandom) & ~exp_oh;
      for (int n = 0; n < NSLAVE; n++) bus.s_dat_i[32*n +: 32] = $urandom;
      if (idx < NSLAVE) bus.s_dat_i[32*idx +: 32] = v.rdata;
      if (bus.s_cyc_o != '0 || bus.s_stb_o) begin
        waits++;
        if (bus.s_cyc_o !== exp_oh || bus.s_stb_o !== 1'b1) cyc_bad++;
        if (bus.s_adr_o !== v.adr || bus.s_dat_o !== v.wdat ||
            bus.s_sel_o !== v.sel || bus.s_we_o !== v.we) req_bad++;
        if (waits - 1 == v.d) begin
          if (v.resp == 1 || v.resp == 3) bus.s_ack_i[v.cs[2:0]] = 1'b1;
          if (v.resp == 2 || v.resp == 3) bus.s_err_i[v.cs[2:0]] = 1'b1;
        end
      end
      if (done) begin bus.cyc_i = 1'b0; bus.stb_i = 1'b0; end
    end
    bus.cyc_i = 1'b0; bus.stb_i = 1'b0;
    check("ack", 32'(got_ack), 32'(v.exp_ack));
    check("err", 32'(got_err), 32'(!v.exp_ack));
    check("timeout_o", 32'(got_tmo), 32'(v.exp_tmo));
    check("waits", 32'(waits), 32'(v.exp_waits));
    check("s_cyc_onehot", 32'(cyc_bad), 32'd0);
    check("s_req_stable", 32'(req_bad), 32'd0);
    check("ack_and_err", 32'(both), 32'd0);
    @(negedge clk);
    bus.s_ack_i = '0; bus.s_err_i = '0;
    check("pulse_ack", 32'(bus.ack_o), 32'd0);
    check("pulse_err", 32'(bus.err_o), 32'd0);
    check("pulse_tmo", 32'(bus.timeout_o), 32'd0);
    check("dat_o", bus.dat_o, v.exp_dat);
    check("buserr_adr", bus.buserr_adr_o, v.exp_buserr);
  endtask

  task automatic check_all_zero();
    check("z_s_cyc", 32'(bus.s_cyc_o), 32'd0);
    check("z_s_stb", 32'(bus.s_stb_o), 32'd0);
    check("z_ack_err_tmo", {29'd0, bus.ack_o, bus.err_o, bus.timeout_o}, 32'd0);
    check("z_dat_o", bus.dat_o, 32'd0);
    check("z_buserr", bus.buserr_adr_o, 32'd0);
    check("z_s_adr", bus.s_adr_o, 32'd0);
    check("z_s_dat", bus.s_dat_o, 32'd0);
    check("z_s_sel_we", {27'd0, bus.s_sel_o, bus.s_we_o}, 32'd0);
  endtask

  initial begin
    vec_t v;
    int acks, run, maxrun, errs, reqbad, stray;
    logic [31:0] first_dat;

    tbl[0] = mk(4'd7, 1'b0, 32'h0000_0010, 32'h0, 4'hF, 1'b0, 3, 1, 32'hDEAD_BEEF,
                1'b1, 1'b0, 4, 32'hDEAD_BEEF, 32'h0);
    tbl[1] = mk(4'd0, 1'b1, 32'h5000_0000, 32'h0, 4'hF, 1'b0, 0, 0, 32'h0,
                1'b0, 1'b0, 0, 32'hDEAD_BEEF, 32'h5000_0000);
    tbl[2] = mk(4'd4, 1'b0, 32'h4000_0020, 32'h0, 4'hF, 1'b0, 0, 0, 32'h0,
                1'b0, 1'b1, 16, 32'hDEAD_BEEF, 32'h4000_0020);
    tbl[3] = mk(4'd2, 1'b0, 32'h2000_0004, 32'h0, 4'h1, 1'b0, 2, 3, 32'hCAFE_0002,
                1'b0, 1'b0, 3, 32'hDEAD_BEEF, 32'h2000_0004);
    tbl[4] = mk(4'd5, 1'b0, 32'h0000_0050, 32'h1111_2222, 4'hF, 1'b1, 0, 1, 32'h0A0A_0A0A,
                1'b1, 1'b0, 1, 32'h0A0A_0A0A, 32'h2000_0004);
    tbl[5] = mk(4'd6, 1'b0, 32'h0000_0060, 32'h3333_4444, 4'h3, 1'b1, 0, 1, 32'h0B0B_0B0B,
                1'b1, 1'b0, 1, 32'h0B0B_0B0B, 32'h2000_0004);
    tbl[6] = mk(4'd3, 1'b0, 32'h3000_0030, 32'h0, 4'hC, 1'b0, 15, 1, 32'h1234_5678,
                1'b1, 1'b0, 16, 32'h1234_5678, 32'h2000_0004);
    tbl[7] = mk(4'd3, 1'b0, 32'h3000_0070, 32'h0, 4'hC, 1'b0, 16, 1, 32'h8765_4321,
                1'b0, 1'b1, 16, 32'h1234_5678, 32'h3000_0070);
    tbl[8] = mk(4'd1, 1'b0, 32'h1000_0100, 32'h5A5A_5A5A, 4'h8, 1'b1, 0, 2, 32'h0,
                1'b0, 1'b0, 1, 32'h1234_5678, 32'h1000_0100);

    drive_idle();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    ctx = "reset";
    check_all_zero();
    rst = 1'b0;

    for (int i = 0; i < 9; i++) begin
      ctx = $sformatf("vec%0d", i);
      run_txn(tbl[i]);
    end
    last_dat    = tbl[8].exp_dat;
    last_buserr = tbl[8].exp_buserr;

    // Back-to-back writes to cs=5 then cs=6 with the master holding cyc/stb.
    ctx = "b2b";
    bus.cyc_i = 1'b1; bus.stb_i = 1'b1; bus.we_i = 1'b1;
    bus.adr_i = 32'h0000_0050; bus.dat_i = 32'h1111_2222; bus.sel_i = 4'hF;
    bus.chipselect = 4'd5; bus.fault = 1'b0;
    bus.s_dat_i = '0;
    bus.s_dat_i[32*5 +: 32] = 32'h5555_0005;
    bus.s_dat_i[32*6 +: 32] = 32'h6666_0006;
    acks = 0; run = 0; maxrun = 0; errs = 0; reqbad = 0; stray = 0; first_dat = '0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (bus.ack_o) begin acks++; run++; if (run > maxrun) maxrun = run; end
      else run = 0;
      if (bus.err_o) errs++;
      bus.s_ack_i = '0;
      bus.s_ack_i[2] = 1'b1;
      if (bus.s_cyc_o[5]) begin
        if (bus.s_dat_o !== 32'h1111_2222 || bus.s_sel_o !== 4'hF) reqbad++;
        bus.s_ack_i[5] = 1'b1;
      end
      if (bus.s_cyc_o[6]) begin
        if (bus.s_dat_o !== 32'h3333_4444 || bus.s_sel_o !== 4'h3) reqbad++;
        bus.s_ack_i[6] = 1'b1;
      end
      if (bus.s_cyc_o[2]) stray++;
      if (bus.ack_o && acks == 1) begin
        first_dat = bus.dat_o;
        bus.adr_i = 32'h0000_0060; bus.dat_i = 32'h3333_4444; bus.sel_i = 4'h3;
        bus.chipselect = 4'd6;
      end
      if (bus.ack_o && acks == 2) begin bus.cyc_i = 1'b0; bus.stb_i = 1'b0; end
    end
    bus.s_ack_i = '0;
    check("ack_pulses", 32'(acks), 32'd2);
    check("ack_width", 32'(maxrun), 32'd1);
    check("err_count", 32'(errs), 32'd0);
    check("req_match", 32'(reqbad), 32'd0);
    check("stray_cyc", 32'(stray), 32'd0);
    check("first_dat", first_dat, 32'h5555_0005);
    check("second_dat", bus.dat_o, 32'h6666_0006);
    last_dat = 32'h6666_0006;

    // Abort in the second WAIT cycle, then prove the watchdog restarted from zero.
    ctx = "abort";
    bus.cyc_i = 1'b1; bus.stb_i = 1'b1; bus.we_i = 1'b0;
    bus.adr_i = 32'h3300_0000; bus.chipselect = 4'd3; bus.fault = 1'b0;
    @(negedge clk);
    check("abort_wait0", 32'(bus.s_cyc_o), 32'h08);
    @(negedge clk);
    bus.cyc_i = 1'b0; bus.stb_i = 1'b0;
    errs = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (bus.s_cyc_o != '0 || bus.s_stb_o || bus.ack_o || bus.err_o) errs++;
    end
    check("abort_quiet", 32'(errs), 32'd0);
    check("abort_buserr", bus.buserr_adr_o, last_buserr);
    v = mk(4'd3, 1'b0, 32'h3300_0100, 32'h0, 4'hF, 1'b0, 0, 0, 32'h0, 1'b0, 1'b0, 0, 32'h0, 32'h0);
    model(v);
    ctx = "abort_tmo";
    run_txn(v);

    for (int i = 0; i < 40; i++) begin
      v = mk(4'($urandom_range(0, 7)), ($urandom_range(0, 7) == 0), $urandom, $urandom,
             4'($urandom), 1'($urandom), $urandom_range(0, 19), $urandom_range(0, 3),
             $urandom, 1'b0, 1'b0, 0, 32'h0, 32'h0);
      model(v);
      ctx = $sformatf("rnd%0d", i);
      run_txn(v);
    end

    // Reset asserted in the second WAIT cycle.
    ctx = "rst_wait";
    bus.cyc_i = 1'b1; bus.stb_i = 1'b1; bus.we_i = 1'b1;
    bus.adr_i = 32'h7700_0000; bus.dat_i = 32'h7777_7777; bus.sel_i = 4'hF;
    bus.chipselect = 4'd3; bus.fault = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_in_wait", 32'(bus.s_cyc_o), 32'h08);
    rst = 1'b1;
    bus.cyc_i = 1'b0; bus.stb_i = 1'b0;
    @(negedge clk);
    check_all_zero();
    rst = 1'b0;
    last_dat = '0;
    last_buserr = '0;

    for (int i = 0; i < 10; i++) begin
      v = mk(4'($urandom_range(1, 7)), 1'b0, $urandom, $urandom, 4'($urandom), 1'($urandom),
             $urandom_range(0, 17), $urandom_range(0, 3), $urandom,
             1'b0, 1'b0, 0, 32'h0, 32'h0);
      model(v);
      ctx = $sformatf("post_rst%0d", i);
      run_txn(v);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
